// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline results take the register-file port first,
// divider results queue in a small FIFO and drain on idle pipeline cycles.
module wb_arbiter #(
    parameter int WORD_WIDTH   = 32,
    parameter int REGFILE_BITS = 5,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            pipe_wr_en,
    input  logic [WORD_WIDTH-1:0]           pipe_wr_data,
    input  logic [REGFILE_BITS-1:0]         pipe_dest,
    input  logic                            div_valid,
    input  logic [WORD_WIDTH-1:0]           div_data,
    input  logic [REGFILE_BITS-1:0]         div_dest,
    output logic                            div_ready,
    output logic                            rf_wr_en,
    output logic [WORD_WIDTH-1:0]           rf_wr_data,
    output logic [REGFILE_BITS-1:0]         rf_dest_addr,
    output logic [(1<<REGFILE_BITS)-1:0]    pending_mask,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH   = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WORD_WIDTH-1:0]   r_data [FIFO_DEPTH];
    logic [REGFILE_BITS-1:0] r_dest [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   r_live;
    logic [PTR_W-1:0]        r_rptr;
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W:0]          r_count;

    logic                    w_pw;
    logic                    w_empty;
    logic                    w_acc;
    logic                    w_div_nz;
    logic                    w_pop;
    logic                    w_bypass;
    logic                    w_push;
    logic [FIFO_DEPTH-1:0]   w_live_nxt;

    assign w_pw      = pipe_wr_en && (pipe_dest != '0);
    assign w_empty   = (r_count == '0);
    assign div_ready = nrst && (r_count < DEPTH);
    assign w_acc     = div_valid && div_ready;
    assign w_div_nz  = (div_dest != '0);
    assign w_pop     = nrst && !w_pw && !w_empty;
    assign w_bypass  = nrst && !w_pw && w_empty && w_acc && w_div_nz;
    assign w_push    = w_acc && w_div_nz && !w_bypass;
    assign fifo_count = r_count;

    always_comb begin
        rf_wr_en     = 1'b0;
        rf_wr_data   = '0;
        rf_dest_addr = '0;
        if (nrst) begin
            if (w_pw) begin
                rf_wr_en     = 1'b1;
                rf_wr_data   = pipe_wr_data;
                rf_dest_addr = pipe_dest;
            end else if (!w_empty) begin
                // a killed head is still consumed, just not written
                rf_wr_en     = r_live[r_rptr];
                rf_wr_data   = r_data[r_rptr];
                rf_dest_addr = r_dest[r_rptr];
            end else if (w_bypass) begin
                rf_wr_en     = 1'b1;
                rf_wr_data   = div_data;
                rf_dest_addr = div_dest;
            end
        end
    end

    always_comb begin
        w_live_nxt = r_live;
        // a younger pipeline write to the same register kills queued results
        if (w_pw) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (r_dest[i] == pipe_dest) w_live_nxt[i] = 1'b0;
            end
        end
        if (w_pop)  w_live_nxt[r_rptr] = 1'b0;
        if (w_push) w_live_nxt[r_wptr] = !(w_pw && (pipe_dest == div_dest));
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_live[i]) pending_mask[r_dest[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_live  <= '0;
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            r_live <= w_live_nxt;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr] <= div_data;
            r_dest[r_wptr] <= div_dest;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_arbiter;

    localparam int FD = 2;

    logic        clk;
    logic        nrst;
    logic        pipe_wr_en;
    logic [31:0] pipe_wr_data;
    logic [4:0]  pipe_dest;
    logic        div_valid;
    logic [31:0] div_data;
    logic [4:0]  div_dest;
    logic        div_ready;
    logic        rf_wr_en;
    logic [31:0] rf_wr_data;
    logic [4:0]  rf_dest_addr;
    logic [31:0] pending_mask;
    logic [1:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.WORD_WIDTH(32), .REGFILE_BITS(5), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .nrst(nrst),
        .pipe_wr_en(pipe_wr_en), .pipe_wr_data(pipe_wr_data),
        .pipe_dest(pipe_dest),
        .div_valid(div_valid), .div_data(div_data), .div_dest(div_dest),
        .div_ready(div_ready),
        .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
        .rf_dest_addr(rf_dest_addr),
        .pending_mask(pending_mask), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file built from the DUT's write port
    logic [31:0] dut_rf [32];
    initial for (int i = 0; i < 32; i++) dut_rf[i] = '0;
    always @(posedge clk) if (rf_wr_en) dut_rf[rf_dest_addr] <= rf_wr_data;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // reference model: ordered queue of pending divider results
    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
        bit          live;
    } ent_t;
    ent_t mq[$];
    bit   mvalid = 0;

    always begin : compare
        bit          pw, acc, rdy, en, pop, byp;
        logic [4:0]  ea;
        logic [31:0] ed, em;
        ent_t        e;
        @(negedge clk);
        pw  = pipe_wr_en && pipe_dest != 0;
        rdy = nrst && (mq.size() < FD);
        acc = div_valid && rdy;
        en = 0; ea = 0; ed = 0; pop = 0; byp = 0;
        if (nrst) begin
            if (pw) begin
                en = 1; ea = pipe_dest; ed = pipe_wr_data;
            end else if (mq.size() > 0) begin
                pop = 1; en = mq[0].live; ea = mq[0].d; ed = mq[0].v;
            end else if (acc && div_dest != 0) begin
                byp = 1; en = 1; ea = div_dest; ed = div_data;
            end
        end
        em = 0;
        foreach (mq[i]) if (mq[i].live) em[mq[i].d] = 1'b1;
        if (mvalid) begin
            chk("m_div_ready", div_ready, rdy);
            chk("m_rf_wr_en", rf_wr_en, en);
            if (en) begin
                chk("m_rf_dest_addr", rf_dest_addr, ea);
                chk("m_rf_wr_data", rf_wr_data, ed);
            end
            chk("m_fifo_count", fifo_count, mq.size());
            chk("m_pending_mask", pending_mask, em);
        end
        @(posedge clk);
        if (!nrst) begin
            mq.delete();
            mvalid = 1;
        end else if (mvalid) begin
            if (pw) foreach (mq[i]) if (mq[i].d == pipe_dest) mq[i].live = 0;
            if (pop) void'(mq.pop_front());
            if (acc && div_dest != 0 && !byp) begin
                e.d = div_dest;
                e.v = div_data;
                e.live = !(pw && pipe_dest == div_dest);
                mq.push_back(e);
            end
        end
    end

    task automatic drive(bit pe, logic [4:0] pd, logic [31:0] pdat,
                         bit dv, logic [4:0] dd, logic [31:0] ddat);
        pipe_wr_en = pe; pipe_dest = pd; pipe_wr_data = pdat;
        div_valid = dv; div_dest = dd; div_data = ddat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0;
        drive(1, 5, 32'h1, 1, 7, 32'h2);
        tick();
        chk("rst_wr_en", rf_wr_en, 0);
        chk("rst_div_ready", div_ready, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_mask", pending_mask, 0);
        nrst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();

        // pipe only
        drive(1, 5, 32'h11, 0, 0, 0);
        #1;
        chk("pipe_en", rf_wr_en, 1);
        chk("pipe_addr", rf_dest_addr, 5);
        chk("pipe_data", rf_wr_data, 32'h11);
        tick();
        chk("pipe_count", fifo_count, 0);

        // bypass
        drive(0, 0, 0, 1, 7, 32'hDEAD);
        #1;
        chk("byp_en", rf_wr_en, 1);
        chk("byp_addr", rf_dest_addr, 7);
        chk("byp_data", rf_wr_data, 32'hDEAD);
        chk("byp_ready", div_ready, 1);
        tick();
        chk("byp_count", fifo_count, 0);

        // collision and drain
        drive(1, 3, 32'h33, 1, 9, 32'hBEEF);
        #1;
        chk("col_addr", rf_dest_addr, 3);
        tick();
        chk("col_count", fifo_count, 1);
        chk("col_mask9", pending_mask[9], 1);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("drain_en", rf_wr_en, 1);
        chk("drain_addr", rf_dest_addr, 9);
        chk("drain_data", rf_wr_data, 32'hBEEF);
        tick();
        chk("drain_count", fifo_count, 0);
        chk("drain_mask", pending_mask, 0);

        // full back-pressure
        drive(1, 10, 32'hA, 1, 1, 32'h100);
        tick();
        drive(1, 11, 32'hB, 1, 2, 32'h200);
        tick();
        chk("full_count", fifo_count, 2);
        drive(1, 12, 32'hC, 1, 4, 32'h400);
        #1;
        chk("full_ready", div_ready, 0);
        tick();
        drive(0, 0, 0, 1, 4, 32'h400);
        #1;
        chk("bp_pop1_addr", rf_dest_addr, 1);
        chk("bp_pop1_ready", div_ready, 0);
        tick();
        #1;
        chk("bp_pop2_addr", rf_dest_addr, 2);
        chk("bp_pop2_ready", div_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("bp_pop3_addr", rf_dest_addr, 4);
        chk("bp_pop3_data", rf_wr_data, 32'h400);
        tick();
        chk("bp_count", fifo_count, 0);

        // WAW kill through a later pipeline write
        drive(1, 8, 32'h88, 1, 6, 32'hAAAA);
        tick();
        chk("waw_mask6", pending_mask[6], 1);
        drive(1, 6, 32'h5555, 0, 0, 0);
        tick();
        chk("waw_kill_mask", pending_mask[6], 0);
        chk("waw_kill_count", fifo_count, 1);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("waw_pop_en", rf_wr_en, 0);
        tick();
        chk("waw_pop_count", fifo_count, 0);
        chk("waw_rf6", dut_rf[6], 32'h5555);

        // same-cycle collision on one register
        drive(1, 6, 32'h6666, 1, 6, 32'h7777);
        tick();
        chk("same_count", fifo_count, 1);
        chk("same_mask", pending_mask, 0);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("same_pop_en", rf_wr_en, 0);
        tick();
        chk("same_rf6", dut_rf[6], 32'h6666);

        // x0 destination is accepted and dropped
        drive(0, 0, 0, 1, 0, 32'h99);
        #1;
        chk("x0_ready", div_ready, 1);
        chk("x0_en", rf_wr_en, 0);
        tick();
        chk("x0_count", fifo_count, 0);

        // reset mid-operation
        drive(1, 13, 32'hD, 1, 14, 32'hE);
        tick();
        drive(1, 15, 32'hF, 1, 16, 32'h10);
        tick();
        chk("mid_count", fifo_count, 2);
        nrst = 1'b0;
        drive(1, 17, 32'h12, 1, 18, 32'h13);
        #1;
        chk("mid_rst_en", rf_wr_en, 0);
        chk("mid_rst_ready", div_ready, 0);
        tick();
        nrst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("mid_count0", fifo_count, 0);
        chk("mid_mask0", pending_mask, 0);
        #1;
        chk("mid_no_pop", rf_wr_en, 0);
        tick();
        tick();
        chk("mid_rf14", dut_rf[14], 0);
        chk("mid_rf16", dut_rf[16], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
